// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Geometry constants, address field widths, FSM encoding and the
// registered memory-request payload used by the controller.
package dcache_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned LINE_W         = 256;
  localparam int unsigned NUM_LINES      = 32;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int unsigned WSEL_W         = $clog2(WORDS_PER_LINE);
  localparam int unsigned OFFSET_W       = 5;
  localparam int unsigned INDEX_W        = $clog2(NUM_LINES);
  localparam int unsigned TAG_W          = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } state_e;

  // Request currently presented to data memory.
  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } mem_req_t;

  // Select one 32-bit word out of a cache line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [WSEL_W-1:0] sel);
    return line[sel*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_mem_if.sv
// Line-wide request/ack bus between the cache controller and data memory.
//   mem_en_o    request valid          mem_we_o    1 = write-back, 0 = fetch
//   mem_addr_o  line-aligned address   mem_wdata_o victim line
//   mem_rdata_i fetched line           mem_ack_i   one-cycle completion pulse
// Signal suffixes are from the controller's point of view.
interface dcache_mem_if;
  import dcache_pkg::*;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport master (
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the direct-mapped cache, built from flops.
//   rd_*      asynchronous read of one line (valid, dirty, tag, data)
//   line_we_i full-line fill: writes tag+data, sets valid, clears dirty
//   word_we_i single-word store into the selected word, sets dirty
//   clr_dirty_i clears dirty after the victim has been written back
// Only valid/dirty are reset; tag/data are qualified by valid.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic               rd_dirty_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]  rd_data_o,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic               line_we_i,
  input  logic [TAG_W-1:0]   line_tag_i,
  input  logic [LINE_W-1:0]  line_data_i,
  input  logic               word_we_i,
  input  logic [WSEL_W-1:0]  word_sel_i,
  input  logic [WORD_W-1:0]  word_data_i,
  input  logic               clr_dirty_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Line status bits; reset invalidates every line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end else if (clr_dirty_i) begin
      dirty_q[wr_idx_i] <= 1'b0;
    end
  end

  // Tag and data arrays.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[wr_idx_i]  <= line_tag_i;
      data_q[wr_idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[wr_idx_i][word_sel_i*WORD_W +: WORD_W] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
//   clk_i, rst_i    clock, asynchronous active-high reset
//   cpu_req_i       MEM-stage access valid     cpu_we_i    1 = store
//   cpu_addr_i      word-aligned byte address  cpu_wdata_i store data
//   cpu_rdata_o     load data (hit word, else last loaded value)
//   cpu_stall_o     pipeline freeze while a miss is being serviced
//   mem             line request/ack bus to data memory (master side)
// Hits complete in the same cycle; misses write back a dirty victim and
// refill the line, after which the access hits in IDLE.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_wdata_i,
  output logic [WORD_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  dcache_mem_if.master      mem
);

  state_e   state_q, state_d;
  mem_req_t req_q, req_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic [WSEL_W-1:0]  cpu_word;
  logic [INDEX_W-1:0] cpu_index;
  logic [TAG_W-1:0]   cpu_tag;
  logic               unused_addr_bits;

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              hit;
  logic [WORD_W-1:0] hit_word;
  logic              line_we, word_we, clr_dirty;

  assign cpu_word         = cpu_addr_i[OFFSET_W-1:2];
  assign cpu_index        = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign cpu_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  dcache_sram u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (cpu_index),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_idx_i    (cpu_index),
    .line_we_i   (line_we),
    .line_tag_i  (cpu_tag),
    .line_data_i (mem.mem_rdata_i),
    .word_we_i   (word_we),
    .word_sel_i  (cpu_word),
    .word_data_i (cpu_wdata_i),
    .clr_dirty_i (clr_dirty)
  );

  assign hit      = rd_valid && (rd_tag == cpu_tag);
  assign hit_word = line_word(rd_data, cpu_word);

  // State, memory request and last-load registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state, memory request and array write controls.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    line_we   = 1'b0;
    word_we   = 1'b0;
    clr_dirty = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            if (cpu_we_i) word_we = 1'b1;
            else          rdata_d = hit_word;
          end else if (rd_valid && rd_dirty) begin
            state_d     = ST_WRITEBACK;
            req_d.en    = 1'b1;
            req_d.we    = 1'b1;
            req_d.addr  = {rd_tag, cpu_index, {OFFSET_W{1'b0}}};
            req_d.wdata = rd_data;
          end else begin
            state_d    = ST_REFILL;
            req_d.en   = 1'b1;
            req_d.we   = 1'b0;
            req_d.addr = {cpu_tag, cpu_index, {OFFSET_W{1'b0}}};
          end
        end
      end
      ST_WRITEBACK: begin
        if (mem.mem_ack_i) begin
          clr_dirty  = 1'b1;
          state_d    = ST_REFILL;
          req_d.we   = 1'b0;
          req_d.addr = {cpu_tag, cpu_index, {OFFSET_W{1'b0}}};
        end
      end
      ST_REFILL: begin
        if (mem.mem_ack_i) begin
          line_we  = 1'b1;
          state_d  = ST_IDLE;
          req_d.en = 1'b0;
          req_d.we = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem.mem_en_o    = req_q.en;
  assign mem.mem_we_o    = req_q.we;
  assign mem.mem_addr_o  = req_q.addr;
  assign mem.mem_wdata_o = req_q.wdata;

  // Load hits bypass the register so the word is returned in the same cycle.
  assign cpu_rdata_o = (state_q == ST_IDLE && cpu_req_i && !cpu_we_i && hit) ? hit_word : rdata_q;

  // Stall is held low while reset is asserted even if a request is pending.
  assign cpu_stall_o = !rst_i && ((state_q != ST_IDLE) || (cpu_req_i && !hit));

endmodule
